reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Reset sequencer downstream of the reset synchroniser in the recorder's clock domain. Turns one synchronised active-low reset plus a debounced reset request (push-button or control register) into a minimum-width reset that is released per stage, in order. Reset fans out to NUM_STAGES subsystems (e.g. TS input, buffer, storage writer), each released a fixed gap after the previous one. A busy flag and a done pulse tell control logic when the design is out of reset.

## Interface
- NUM_STAGES, 3: number of independent reset outputs, ≥1
- HOLD_CYCLES, 16: minimum cycles all outputs stay asserted after reset/request removal, ≥1
- STAGE_GAP, 8: cycles between successive stage releases (and HOLD end to stage 0), ≥1
- DEBOUNCE_CYCLES, 4: consecutive high samples of resetRequest needed to trigger, ≥1

- clock  input  1  single system clock; all logic on rising edge
- resetN  input  1  asynchronous, active-low reset (deassertion already synchronised upstream)
- resetRequest  input  1  synchronous active-high reset request, level
- resetOutN  output  NUM_STAGES  active-low per-stage resets, registered; bit 0 released first
- resetBusy  output  1  high while any resetOutN bit is low
- resetDone  output  1  one-cycle pulse when the last stage is released

## Operation
- resetN low (async, immediate): state=HOLD, all counters 0, resetOutN=all 0, resetBusy=1, resetDone=0.
- States: HOLD, RELEASE, RUN.
- HOLD: all outputs low. holdCount increments on each edge where resetRequest is sampled low; cleared to 0 on any edge where it is sampled high. When holdCount reaches HOLD_CYCLES → RELEASE, gapCount=0, stageIdx=0.
- RELEASE: gapCount increments each edge. On reaching STAGE_GAP, resetOutN[stageIdx] goes high, gapCount=0, stageIdx++. The edge that releases bit NUM_STAGES-1 also sets state=RUN, resetBusy=0, resetDone=1.
- RUN: outputs all high; resetDone returns to 0 the next edge.
- Debounce: debCount increments (saturating at DEBOUNCE_CYCLES) each edge resetRequest is sampled high; cleared when sampled low. On the edge debCount reaches DEBOUNCE_CYCLES while in RELEASE or RUN: state=HOLD, resetOutN=all 0, resetBusy=1, resetDone=0, holdCount=0, gapCount=0, stageIdx=0. In HOLD, debounce has no effect beyond the holdCount clear.
- Pulses shorter than DEBOUNCE_CYCLES samples are ignored in RELEASE/RUN and change no output.
- Released stages never reassert individually; reassertion is always all stages together.
- Counter widths: $clog2 of (max value + 1); no wrap-around is reachable.

## Timing
- Edge k = k-th rising edge with resetN high (edge 1 is the first after deassertion), resetRequest low.
- Power-up, defaults: HOLD exits at edge 16; resetOutN[0] high at edge 24, [1] at 32, [2] at 40; resetBusy low and resetDone high at edge 40; resetDone low at edge 41.
- General: stage i released at edge HOLD_CYCLES + (i+1)·STAGE_GAP.
- Request latency: resetRequest high before edge n and held → all outputs low at edge n+DEBOUNCE_CYCLES-1 (defaults: n+3).
- After request removal (first low sample at edge m) the release schedule is the power-up schedule with edge 1 replaced by edge m.
- Request and release of last stage on same edge: request wins; outputs go/stay low and resetDone stays 0.
- resetN asserted mid-operation: outputs low asynchronously, not waiting for a clock.

## Test plan
- Power-on: resetN low 5 cycles then high → resetOutN 000→001@24→011@32→111@40; resetBusy falls @40; resetDone high exactly @40.
- Glitch rejection in RUN: resetRequest high for 3 cycles → resetOutN stays 111, resetDone stays 0, resetBusy stays 0.
- Valid request in RUN: resetRequest high 10 cycles from edge n → resetOutN=000 @n+3; first low sample m=n+10 → 001@m+23, 111@m+39, one resetDone pulse.
- Request during RELEASE (after stage 0 released, before stage 1): 4-cycle request → resetOutN back to 000, full schedule restarts from request removal.
- Async reset in RUN: resetN low between edges → resetOutN=000 and resetBusy=1 immediately; restart matches power-on timing.
- Parameter sweep NUM_STAGES=1, HOLD_CYCLES=1, STAGE_GAP=1, DEBOUNCE_CYCLES=1: resetOutN high and resetDone pulse @2 after power-on; single-cycle request → resetOutN low the same edge it is sampled.

Source files
------------

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - debounced, minimum-width, per-stage ordered reset release
module reset_sequencer #(
  parameter int NUM_STAGES      = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  resetRequest,
  output logic [NUM_STAGES-1:0] resetOutN,
  output logic                  resetBusy,
  output logic                  resetDone
);

  localparam int HoldWidth  = $clog2(HOLD_CYCLES + 1);
  localparam int GapWidth   = $clog2(STAGE_GAP + 1);
  localparam int DebWidth   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int StageWidth = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [HoldWidth-1:0]  HoldMax   = HoldWidth'(HOLD_CYCLES);
  localparam logic [GapWidth-1:0]   GapMax    = GapWidth'(STAGE_GAP);
  localparam logic [DebWidth-1:0]   DebMax    = DebWidth'(DEBOUNCE_CYCLES);
  localparam logic [DebWidth-1:0]   DebLast   = DebWidth'(DEBOUNCE_CYCLES - 1);
  localparam logic [StageWidth-1:0] LastStage = StageWidth'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] FirstBit  = NUM_STAGES'(1);

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } seqState_e;

  seqState_e             state, stateNext;
  logic [HoldWidth-1:0]  holdCount, holdNext, holdInc;
  logic [GapWidth-1:0]   gapCount, gapNext, gapInc;
  logic [DebWidth-1:0]   debCount, debNext;
  logic [StageWidth-1:0] stageIdx, stageNext;
  logic [NUM_STAGES-1:0] outNext;
  logic                  busyNext;
  logic                  doneNext;
  logic                  debTrigger;

  // State, counters and registered outputs; resetN forces everything into HOLD without a clock
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= HOLD;
      holdCount <= '0;
      gapCount  <= '0;
      debCount  <= '0;
      stageIdx  <= '0;
      resetOutN <= '0;
      resetBusy <= 1'b1;
      resetDone <= 1'b0;
    end else begin
      state     <= stateNext;
      holdCount <= holdNext;
      gapCount  <= gapNext;
      debCount  <= debNext;
      stageIdx  <= stageNext;
      resetOutN <= outNext;
      resetBusy <= busyNext;
      resetDone <= doneNext;
    end
  end

  // Debounce, hold timing and staged release; a debounced request outranks any release on the same edge
  always_comb begin
    stateNext  = state;
    holdNext   = holdCount;
    gapNext    = gapCount;
    stageNext  = stageIdx;
    outNext    = resetOutN;
    busyNext   = resetBusy;
    doneNext   = 1'b0;
    holdInc    = holdCount + 1'b1;
    gapInc     = gapCount + 1'b1;
    debNext    = debCount;
    debTrigger = 1'b0;

    // The trigger fires only on the edge the count first reaches its limit, not while it sits saturated
    if (resetRequest) begin
      if (debCount != DebMax) begin
        debNext = debCount + 1'b1;
      end
      debTrigger = (debCount == DebLast);
    end else begin
      debNext = '0;
    end

    case (state)
      HOLD: begin
        outNext  = '0;
        busyNext = 1'b1;
        if (resetRequest) begin
          holdNext = '0;
        end else if (holdInc == HoldMax) begin
          holdNext  = '0;
          gapNext   = '0;
          stageNext = '0;
          stateNext = RELEASE;
        end else begin
          holdNext = holdInc;
        end
      end

      RELEASE: begin
        if (debTrigger) begin
          stateNext = HOLD;
          outNext   = '0;
          busyNext  = 1'b1;
          holdNext  = '0;
          gapNext   = '0;
          stageNext = '0;
        end else if (gapInc == GapMax) begin
          // Stages release strictly in order, so shifting a one in releases resetOutN[stageIdx]
          outNext = (resetOutN << 1) | FirstBit;
          gapNext = '0;
          if (stageIdx == LastStage) begin
            stateNext = RUN;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end else begin
            stageNext = stageIdx + 1'b1;
          end
        end else begin
          gapNext = gapInc;
        end
      end

      RUN: begin
        if (debTrigger) begin
          stateNext = HOLD;
          outNext   = '0;
          busyNext  = 1'b1;
          holdNext  = '0;
          gapNext   = '0;
          stageNext = '0;
        end
      end

      default: begin
        stateNext = HOLD;
        outNext   = '0;
        busyNext  = 1'b1;
        holdNext  = '0;
        gapNext   = '0;
        stageNext = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer, default and minimum parameter sets
module tb_reset_sequencer;

  logic       clock;
  logic       resetN0, resetN1;
  logic       req0, req1;
  logic [2:0] resetOutN0;
  logic       busy0, done0;
  logic [0:0] resetOutN1;
  logic       busy1, done1;

  int errors  = 0;
  int checks  = 0;
  int edgeNum = 0;
  int e, n, m, m1, m2;

  typedef struct {
    int         cyc;
    int         dut;
    logic [4:0] exp;
    string      tag;
  } item_t;

  item_t sb[$];

  reset_sequencer dutDefault (
    .clock       (clock),
    .resetN      (resetN0),
    .resetRequest(req0),
    .resetOutN   (resetOutN0),
    .resetBusy   (busy0),
    .resetDone   (done0)
  );

  reset_sequencer #(
    .NUM_STAGES     (1),
    .HOLD_CYCLES    (1),
    .STAGE_GAP      (1),
    .DEBOUNCE_CYCLES(1)
  ) dutMin (
    .clock       (clock),
    .resetN      (resetN1),
    .resetRequest(req1),
    .resetOutN   (resetOutN1),
    .resetBusy   (busy1),
    .resetDone   (done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [4:0] observe(input int dut);
    if (dut == 0) return {resetOutN0, busy0, done0};
    return {2'b00, resetOutN1, busy1, done1};
  endfunction

  task automatic pushOne(input int dut, input int cyc, input logic [2:0] outN,
                         input logic busy, input logic done, input string tag);
    item_t it;
    it.cyc = cyc;
    it.dut = dut;
    it.exp = {outN, busy, done};
    it.tag = tag;
    sb.push_back(it);
  endtask

  task automatic pushRange(input int dut, input int first, input int last, input logic [2:0] outN,
                           input logic busy, input logic done, input string tag);
    for (int c = first; c <= last; c++) pushOne(dut, c, outN, busy, done, $sformatf("%s_e%0d", tag, c - first));
  endtask

  // Expected outputs at relative edge k of a release schedule whose edge 1 lands on absolute edge edge1
  task automatic pushSchedule(input int dut, input int edge1, input int kFrom, input int kTo,
                              input int ns, input int hc, input int gap, input string tag);
    logic [2:0] full;
    full = 3'((1 << ns) - 1);
    for (int k = kFrom; k <= kTo; k++) begin
      logic [2:0] outN;
      outN = '0;
      for (int i = 0; i < ns; i++) begin
        if (k >= hc + (i + 1) * gap) outN[i] = 1'b1;
      end
      pushOne(dut, edge1 + k - 1, outN, outN != full, k == hc + ns * gap, $sformatf("%s_k%0d", tag, k));
    end
  endtask

  task automatic checkNow(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: counts rising edges and compares every expectation due on this edge
  initial begin
    forever begin
      @(posedge clock);
      edgeNum++;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == edgeNum) begin
          logic [4:0] obs;
          obs = observe(sb[i].dut);
          checks++;
          assert (obs === sb[i].exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", sb[i].tag, obs, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    resetN0 = 1'b0;
    resetN1 = 1'b0;
    req0    = 1'b0;
    req1    = 1'b0;
    repeat (5) @(negedge clock);
    checkNow("reset_dflt", observe(0), 5'b000_1_0);
    checkNow("reset_min", observe(1), 5'b000_1_0);

    // Power-on: edge 1 follows deassertion
    e = edgeNum;
    pushSchedule(0, e + 1, 1, 45, 3, 16, 8, "pwr_dflt");
    pushSchedule(1, e + 1, 1, 4, 1, 1, 1, "pwr_min");
    resetN0 = 1'b1;
    resetN1 = 1'b1;
    repeat (45) @(negedge clock);

    // Three-sample glitch in RUN must change nothing
    e = edgeNum;
    pushRange(0, e + 1, e + 8, 3'b111, 1'b0, 1'b0, "glitch");
    req0 = 1'b1;
    repeat (3) @(negedge clock);
    req0 = 1'b0;
    repeat (5) @(negedge clock);

    // Ten-cycle request in RUN
    e = edgeNum;
    n = e + 1;
    m = n + 10;
    pushRange(0, n, n + 2, 3'b111, 1'b0, 1'b0, "req_pre");
    pushRange(0, n + 3, m - 1, 3'b000, 1'b1, 1'b0, "req_hold");
    pushSchedule(0, m, 1, 42, 3, 16, 8, "req_sched");
    req0 = 1'b1;
    repeat (10) @(negedge clock);
    req0 = 1'b0;
    repeat (42) @(negedge clock);

    // Request between stage 0 and stage 1 release
    e  = edgeNum;
    m1 = e + 5;
    m2 = m1 + 30;
    pushRange(0, e + 1, e + 3, 3'b111, 1'b0, 1'b0, "rel_pre");
    pushOne(0, e + 4, 3'b000, 1'b1, 1'b0, "rel_enter");
    pushSchedule(0, m1, 1, 29, 3, 16, 8, "rel_first");
    pushOne(0, m1 + 29, 3'b000, 1'b1, 1'b0, "rel_abort");
    pushSchedule(0, m2, 1, 42, 3, 16, 8, "rel_restart");
    req0 = 1'b1;
    repeat (4) @(negedge clock);
    req0 = 1'b0;
    repeat (26) @(negedge clock);
    req0 = 1'b1;
    repeat (4) @(negedge clock);
    req0 = 1'b0;
    repeat (42) @(negedge clock);

    // Debounce completes on the same edge as the last stage release
    e  = edgeNum;
    m1 = e + 5;
    m2 = m1 + 40;
    pushRange(0, e + 1, e + 3, 3'b111, 1'b0, 1'b0, "col_pre");
    pushOne(0, e + 4, 3'b000, 1'b1, 1'b0, "col_enter");
    pushSchedule(0, m1, 1, 39, 3, 16, 8, "col_first");
    pushOne(0, m1 + 39, 3'b000, 1'b1, 1'b0, "col_tie");
    pushSchedule(0, m2, 1, 42, 3, 16, 8, "col_restart");
    req0 = 1'b1;
    repeat (4) @(negedge clock);
    req0 = 1'b0;
    repeat (36) @(negedge clock);
    req0 = 1'b1;
    repeat (4) @(negedge clock);
    req0 = 1'b0;
    repeat (42) @(negedge clock);

    // Asynchronous reset between edges while in RUN
    checkNow("async_pre", observe(0), 5'b111_0_0);
    #2;
    resetN0 = 1'b0;
    #1;
    checkNow("async_low", observe(0), 5'b000_1_0);
    repeat (2) @(negedge clock);
    e = edgeNum;
    pushSchedule(0, e + 1, 1, 42, 3, 16, 8, "async_restart");
    resetN0 = 1'b1;
    repeat (42) @(negedge clock);

    // Minimum parameters: single-sample request acts on the edge it is sampled
    e = edgeNum;
    pushOne(1, e + 1, 3'b000, 1'b1, 1'b0, "min_req");
    pushSchedule(1, e + 2, 1, 3, 1, 1, 1, "min_sched");
    req1 = 1'b1;
    @(negedge clock);
    req1 = 1'b0;
    repeat (3) @(negedge clock);

    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
